// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage between the PC register and IF/ID.
//
// Issues one memory request per accepted PC and waits for the one-cycle
// mem_ready_i pulse. If IF/ID is stalled when the data arrives, the
// instruction is parked in a hold buffer. A redirect (jump_i) makes the
// fetch in flight or held wrong-path. A request already issued cannot be
// cancelled, so a redirect during BUSY moves the FSM to DROP, which waits
// for the response and then discards it.
//
// Optional feature (macro ICACHE_EN): a 16-entry direct-mapped instruction
// cache (index pc[5:2], tag pc[31:6]). An IDLE hit delivers without a
// memory request. Every response in BUSY or DROP fills the entry at the
// request address. Without the macro, there is no cache storage or logic.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pc_i            fetch address from the PC register
//   chip_enable_i   PC-register enable (0 = no new fetch)
//   jump_i          EX redirect
//   stall_i         stall_ctrl vector, bit 1 = IF/ID stalled
//   mem_req_o       level request to the memory controller
//   mem_addr_o      request address
//   mem_ready_i     response pulse, mem_data_i valid in the same cycle
//   mem_data_i      instruction word from memory
//   if_pc_o         PC of the delivered instruction (registered)
//   if_inst_o       delivered instruction (registered)
//   if_valid_o      one-cycle strobe per delivered instruction
//   stall_req_o     combinational request to freeze the PC
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        chip_enable_i,
    input  logic        jump_i,
    input  logic [5:0]  stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        stall_req_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state;
    logic [31:0] req_addr;
    logic [63:0] hold_buf;      // {pc, inst}
    logic        fetch_ok;
    logic        cache_hit;
    logic        unused_stall;

    assign fetch_ok     = chip_enable_i && !jump_i;
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

`ifdef ICACHE_EN
    logic [31:0] cache_data  [16];
    logic [25:0] cache_tag   [16];
    logic [15:0] cache_valid;
    logic        fill_en;
    logic [31:0] cache_rd_data;

    assign cache_hit     = cache_valid[pc_i[5:2]] && (cache_tag[pc_i[5:2]] == pc_i[31:6]);
    assign cache_rd_data = cache_data[pc_i[5:2]];
    // A response in DROP is still correct data for req_addr, so it fills too.
    assign fill_en       = ((state == ST_BUSY) || (state == ST_DROP)) && mem_ready_i;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            cache_data[req_addr[5:2]] <= mem_data_i;
            cache_tag[req_addr[5:2]]  <= req_addr[31:6];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cache_valid <= '0;
        else if (fill_en)
            cache_valid[req_addr[5:2]] <= 1'b1;
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Reset overrides both combinational outputs in the same cycle.
    assign mem_req_o  = !rst && ((state == ST_BUSY) || (state == ST_DROP));
    assign mem_addr_o = req_addr;

    always_comb begin
        stall_req_o = 1'b0;
        if (!rst && fetch_ok) begin
            case (state)
                ST_IDLE: stall_req_o = !cache_hit;
                ST_BUSY: stall_req_o = !mem_ready_i;
                ST_DROP: stall_req_o = 1'b1;
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_addr   <= '0;
            hold_buf   <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
        end else begin
            if_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_ok) begin
`ifdef ICACHE_EN
                        if (cache_hit) begin
                            if (stall_i[1]) begin
                                hold_buf <= {pc_i, cache_rd_data};
                                state    <= ST_HOLD;
                            end else begin
                                if_pc_o    <= pc_i;
                                if_inst_o  <= cache_rd_data;
                                if_valid_o <= 1'b1;
                            end
                        end else
`endif
                        begin
                            req_addr <= pc_i;
                            state    <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready_i) begin
                        state <= ST_IDLE;
                        if (!jump_i) begin
                            if (stall_i[1]) begin
                                hold_buf <= {req_addr, mem_data_i};
                                state    <= ST_HOLD;
                            end else begin
                                if_pc_o    <= req_addr;
                                if_inst_o  <= mem_data_i;
                                if_valid_o <= 1'b1;
                            end
                        end
                    end else if (jump_i) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (mem_ready_i)
                        state <= ST_IDLE;
                end
                default: begin // ST_HOLD; a redirect wins over stall release
                    if (jump_i) begin
                        state <= ST_IDLE;
                    end else if (!stall_i[1]) begin
                        if_pc_o    <= hold_buf[63:32];
                        if_inst_o  <= hold_buf[31:0];
                        if_valid_o <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scoreboard bench for fetch_unit.
// Stimulus pushes expected {pc, inst} deliveries into a queue; a monitor
// pops on every if_valid_o and compares. Combinational outputs are checked
// inline by the stimulus process.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        chip_enable_i;
    logic        jump_i;
    logic [5:0]  stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        stall_req_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .chip_enable_i (chip_enable_i),
        .jump_i        (jump_i),
        .stall_i       (stall_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_data_i    (mem_data_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o),
        .stall_req_o   (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every delivery must match the oldest expectation.
    always @(negedge clk) begin
        if (if_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, if_valid_o}, 32'd0);
                $display("  (unexpected delivery pc=%h inst=%h)", if_pc_o, if_inst_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("deliver_pc", if_pc_o, e[63:32]);
                check("deliver_inst", if_inst_o, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; chip_enable_i = 1'b1; pc_i = '0; jump_i = 1'b0;
        stall_i = '0; mem_ready_i = 1'b0; mem_data_i = '0;

        // Reset state and combinational override
        tick();
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_stall_req", {31'd0, stall_req_o}, 32'd0);
        check("rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_if_pc", if_pc_o, 32'd0);
        check("rst_if_inst", if_inst_o, 32'd0);
        tick();

        // Basic fetch of pc 0, response after 3 cycles
        rst = 1'b0; chip_enable_i = 1'b1; pc_i = 32'h0;
        #1;
        check("t1_idle_stall", {31'd0, stall_req_o}, 32'd1);
        check("t1_idle_mem_req", {31'd0, mem_req_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t1_busy_mem_req", {31'd0, mem_req_o}, 32'd1);
            check("t1_busy_addr", mem_addr_o, 32'h0);
            check("t1_busy_stall", {31'd0, stall_req_o}, 32'd1);
        end
        tick();
        mem_ready_i = 1'b1; mem_data_i = 32'h0000_0013;
        exp_q.push_back({32'h0, 32'h0000_0013});
        #1;
        check("t1_ready_stall", {31'd0, stall_req_o}, 32'd0);
        check("t1_ready_mem_req", {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_ready_i = 1'b0;

        // Minimum latency: ready in the first BUSY cycle
        chip_enable_i = 1'b1; pc_i = 32'h100;
        tick();
        check("lat_addr", mem_addr_o, 32'h100);
        mem_ready_i = 1'b1; mem_data_i = 32'h1357_9BDF; chip_enable_i = 1'b0;
        exp_q.push_back({32'h100, 32'h1357_9BDF});
        tick();
        mem_ready_i = 1'b0;
        check("lat_valid", {31'd0, if_valid_o}, 32'd1);
        tick();
        check("lat_valid_drops", {31'd0, if_valid_o}, 32'd0);
        check("lat_pc_held", if_pc_o, 32'h100);
        check("lat_inst_held", if_inst_o, 32'h1357_9BDF);

        // Redirect during BUSY -> DROP, wrong-path data discarded
        chip_enable_i = 1'b1; pc_i = 32'h4;
        tick();
        tick();
        jump_i = 1'b1; pc_i = 32'h40;
        #1;
        check("t2_jump_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        jump_i = 1'b0;
        #1;
        check("t2_drop_mem_req", {31'd0, mem_req_o}, 32'd1);
        check("t2_drop_addr", mem_addr_o, 32'h4);
        check("t2_drop_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        mem_ready_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        #1;
        check("t2_drop2_addr", mem_addr_o, 32'h4);
        tick();
        mem_ready_i = 1'b0;
        #1;
        check("t2_idle_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("t2_idle_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        check("t2_new_addr", mem_addr_o, 32'h40);
        mem_ready_i = 1'b1; mem_data_i = 32'h1111_2222; chip_enable_i = 1'b0;
        exp_q.push_back({32'h40, 32'h1111_2222});
        tick();
        mem_ready_i = 1'b0;

        // Stall at response -> HOLD for 4 cycles, then one delivery
        chip_enable_i = 1'b1; pc_i = 32'h8;
        tick();
        stall_i = 6'b000010; mem_ready_i = 1'b1; mem_data_i = 32'hA5A5_0008;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_mem_req", {31'd0, mem_req_o}, 32'd0);
            check("t3_hold_stall", {31'd0, stall_req_o}, 32'd0);
            check("t3_hold_valid", {31'd0, if_valid_o}, 32'd0);
            tick();
        end
        stall_i = '0; chip_enable_i = 1'b0;
        exp_q.push_back({32'h8, 32'hA5A5_0008});
        tick();
        check("t3_release_valid", {31'd0, if_valid_o}, 32'd1);
        check("t3_release_pc", if_pc_o, 32'h8);

        // Jump in HOLD beats stall release; buffer discarded
        chip_enable_i = 1'b1; pc_i = 32'hC;
        tick();
        stall_i = 6'b000010; mem_ready_i = 1'b1; mem_data_i = 32'hCCCC_CCCC; chip_enable_i = 1'b0;
        tick();
        mem_ready_i = 1'b0; stall_i = '0; jump_i = 1'b1;
        tick();
        jump_i = 1'b0; chip_enable_i = 1'b1; pc_i = 32'h30;
        #1;
        check("t3b_idle_after_jump", {31'd0, stall_req_o}, 32'd1);
        tick();
        check("t3b_addr", mem_addr_o, 32'h30);
        mem_ready_i = 1'b1; mem_data_i = 32'h3030_3030; chip_enable_i = 1'b0;
        exp_q.push_back({32'h30, 32'h3030_3030});
        tick();
        mem_ready_i = 1'b0;

        // Reset mid-BUSY, late response ignored
        chip_enable_i = 1'b1; pc_i = 32'h20;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("t4_rst_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        rst = 1'b0; chip_enable_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'hBAD0_BAD0;
        #1;
        check("t4_idle_mem_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        mem_ready_i = 1'b0;
        check("t4_valid", {31'd0, if_valid_o}, 32'd0);
        check("t4_if_pc", if_pc_o, 32'h0);
        check("t4_if_inst", if_inst_o, 32'h0);
        tick();
        check("t4_valid_late", {31'd0, if_valid_o}, 32'd0);

`ifdef ICACHE_EN
        // Cache: miss fills 0x10, second fetch hits, 0x50 aliases and misses
        chip_enable_i = 1'b1; pc_i = 32'h10;
        tick();
        mem_ready_i = 1'b1; mem_data_i = 32'h0101_0101; chip_enable_i = 1'b0;
        exp_q.push_back({32'h10, 32'h0101_0101});
        tick();
        mem_ready_i = 1'b0; chip_enable_i = 1'b1; pc_i = 32'h10;
        exp_q.push_back({32'h10, 32'h0101_0101});
        #1;
        check("c_hit_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("c_hit_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        check("c_hit_valid", {31'd0, if_valid_o}, 32'd1);
        pc_i = 32'h50;
        #1;
        check("c_miss_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        check("c_miss_mem_req", {31'd0, mem_req_o}, 32'd1);
        check("c_miss_addr", mem_addr_o, 32'h50);
        mem_ready_i = 1'b1; mem_data_i = 32'h0505_0505; chip_enable_i = 1'b0;
        exp_q.push_back({32'h50, 32'h0505_0505});
        tick();
        mem_ready_i = 1'b0;
`endif

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  clock, all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 pc_i  input  32  fetch address from the PC register.
REQ-004 chip_enable_i  input  1  PC-register enable; 0 = no fetch activity.
REQ-005 jump_i  input  1  EX redirect; the fetch in flight or held is wrong-path.
REQ-006 stall_i  input  6  stall_ctrl vector; bit 1 = IF/ID stalled.
REQ-007 mem_req_o  output  1  level request to the memory controller.
REQ-008 mem_addr_o  output  32  request address.
REQ-009 mem_ready_i  input  1  one-cycle pulse; mem_data_i is valid in the same cycle.
REQ-010 mem_data_i  input  32  instruction word.
REQ-011 if_pc_o  output  32  PC of the delivered instruction (registered).
REQ-012 if_inst_o  output  32  delivered instruction (registered).
REQ-013 if_valid_o  output  1  if_pc_o/if_inst_o are a new instruction this cycle (registered).
REQ-014 stall_req_o  output  1  combinational request to stall_ctrl to freeze the PC.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY, DROP and HOLD, encoded in 2 bits, plus a 32-bit req_addr register and a 64-bit hold buffer.
REQ-016 IDLE: with chip_enable_i=1 and jump_i=0 the block SHALL latch req_addr<=pc_i and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-017 BUSY: mem_req_o=1 and mem_addr_o=req_addr, held stable until mem_ready_i.
REQ-018 BUSY with mem_ready_i=1 and jump_i=0: with stall_i[1]=0, next cycle if_inst_o=mem_data_i, if_pc_o=req_addr, if_valid_o=1, state IDLE; with stall_i[1]=1, the pair goes to the hold buffer, state HOLD.
REQ-019 BUSY with jump_i=1 and mem_ready_i=0: go to DROP.
REQ-020 BUSY with jump_i=1 and mem_ready_i=1: discard the data, go to IDLE.
REQ-021 DROP: mem_req_o stays 1 with the old address until mem_ready_i, then discard the data and go to IDLE; the memory cannot be cancelled.
REQ-022 HOLD: mem_req_o=0; when stall_i[1]=0 present the buffer with if_valid_o=1 for one cycle and go to IDLE; jump_i=1 in HOLD discards the buffer and goes to IDLE, and jump_i takes priority over stall release.
REQ-023 if_valid_o SHALL be 1 for exactly one cycle per delivered instruction and 0 otherwise; if_pc_o/if_inst_o hold their last value when if_valid_o=0.
REQ-024 stall_req_o = chip_enable_i AND NOT jump_i AND (state IDLE, or DROP, or BUSY with mem_ready_i=0); 0 in HOLD.
REQ-025 mem_req_o SHALL be 0 in IDLE and HOLD; mem_addr_o is don't-care when mem_req_o=0.
REQ-026 With chip_enable_i=0, no new request SHALL start; an in-flight BUSY/DROP completes per REQ-018..021.
REQ-027 Minimum latency: pc_i accepted in cycle N, mem_ready_i in cycle N+k (k>=1), if_valid_o in cycle N+k+1.

Reset
REQ-028 rst=1 SHALL force state IDLE, if_valid_o=0, if_pc_o=0, if_inst_o=0, req_addr=0 and clear the hold buffer, even mid-BUSY/DROP; a memory response arriving after reset while in IDLE SHALL be ignored.
REQ-029 Under rst, mem_req_o=0 and stall_req_o=0 in the same cycle (combinational override).

Configuration
REQ-030 Macro ICACHE_EN: when defined, a 16-entry direct-mapped instruction cache is compiled in (index pc_i[5:2], tag pc_i[31:6], per-entry valid bit).
REQ-031 With ICACHE_EN, an IDLE hit (chip_enable_i=1, jump_i=0) SHALL deliver next cycle per REQ-018 stall rules with no memory request, and stall_req_o=0 that cycle.
REQ-032 With ICACHE_EN, every mem_ready_i response in BUSY or DROP fills the entry at req_addr; all valid bits are cleared by rst.
REQ-033 Without ICACHE_EN, every fetch goes to memory, with no cache storage or logic.

Verification
REQ-034 Release reset, pc_i=0x0, memory returns 0x00000013 after 3 cycles -> mem_addr_o=0x0 during BUSY; stall_req_o=1 for 3 cycles; if_valid_o=1 with if_pc_o=0x0 and if_inst_o=0x00000013 on the next cycle.
REQ-035 Fetch pc 0x4, pulse jump_i in the second BUSY cycle, ready 2 cycles later with 0xDEADBEEF -> DROP entered; 0xDEADBEEF never appears with if_valid_o=1; the next fetch starts at the new pc_i.
REQ-036 Fetch pc 0x8 with stall_i[1]=1 when mem_ready_i arrives, released after 4 cycles -> HOLD for 4 cycles with if_valid_o=0; then one valid cycle with if_pc_o=0x8.
REQ-037 rst asserted mid-BUSY, late mem_ready_i afterwards -> outputs zero, state IDLE, if_valid_o stays 0.
REQ-038 ICACHE_EN: fetch 0x10 twice -> the second fetch has mem_req_o=0, stall_req_o=0, and if_valid_o=1 one cycle later; then fetch 0x50 (same index) -> miss goes to memory.
